// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
// Receive-side elastic buffer between the UART receiver and the CPU register
// interface. Completed bytes and their framing-error flags go into a FIFO.
// The oldest entry is presented first-word-fall-through on the read path.
// The rts line is driven with occupancy hysteresis, and a sticky overrun flag
// records bytes that arrive while the FIFO is full.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-low
//   rst_soft_i   synchronous flush (SOFTRESET), active-high
//   en_i         receive enable; when low, pushes are dropped and rts_o is low
//   push_i       byte-complete strobe from the receiver
//   push_data_i  received byte
//   push_ferr_i  framing error for that byte
//   pop_i        RXDATA read strobe
//   pop_data_o   head byte (fall-through)
//   pop_ferr_o   framing flag of the head entry
//   ready_o      FIFO non-empty
//   level_o      occupancy, 0..DEPTH
//   overrun_o    sticky overrun flag
//   clr_ovr_i    clears overrun_o
//   rts_o        ready-to-send towards the remote transmitter
module uart_rx_buffer #(
    parameter int ADDR_W  = 4,
    parameter int RTS_OFF = 12,
    parameter int RTS_ON  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rst_soft_i,
    input  logic              en_i,
    input  logic              push_i,
    input  logic [7:0]        push_data_i,
    input  logic              push_ferr_i,
    input  logic              pop_i,
    output logic [7:0]        pop_data_o,
    output logic              pop_ferr_o,
    output logic              ready_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overrun_o,
    input  logic              clr_ovr_i,
    output logic              rts_o
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] OFF_C   = (ADDR_W+1)'(RTS_OFF);
    localparam logic [ADDR_W:0] ON_C    = (ADDR_W+1)'(RTS_ON);

    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              rx_ok;
    logic              rts;

    logic              full;
    logic              empty;
    logic              pop_acc;
    logic              push_acc;
    logic              ovr_set;
    logic [ADDR_W:0]   count_nxt;
    logic              rx_ok_nxt;
    logic              flush;

    always_comb begin
        flush     = !rst_i || rst_soft_i;
        full      = (count == DEPTH_C);
        empty     = (count == '0);
        pop_acc   = pop_i && !empty;
        // A full FIFO still takes a byte when a read frees the head slot this cycle.
        push_acc  = push_i && en_i && (!full || pop_acc);
        ovr_set   = push_i && en_i && full && !pop_i;

        count_nxt = count;
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase

        // Hysteresis is evaluated on the next-cycle count so rts moves on the
        // same edge that the occupancy crosses a threshold.
        rx_ok_nxt = rx_ok;
        if (count_nxt >= OFF_C) begin
            rx_ok_nxt = 1'b0;
        end else if (count_nxt <= ON_C) begin
            rx_ok_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            rx_ok   <= 1'b1;
            rts     <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nxt;
            overrun <= ovr_set || (overrun && !clr_ovr_i);
            rx_ok   <= rx_ok_nxt;
            rts     <= en_i && rx_ok_nxt;
        end
    end

    // Storage is not cleared by reset or flush; only the pointers are.
    always_ff @(posedge clk_i) begin
        if (!flush && push_acc) begin
            mem[wr_ptr] <= {push_ferr_i, push_data_i};
        end
    end

    assign pop_data_o = mem[rd_ptr][7:0];
    assign pop_ferr_o = mem[rd_ptr][8];
    assign ready_o    = !empty;
    assign level_o    = count;
    assign overrun_o  = overrun;
    assign rts_o      = rts;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rst_soft_i;
    logic       en_i;
    logic       push_i;
    logic [7:0] push_data_i;
    logic       push_ferr_i;
    logic       pop_i;
    logic [7:0] pop_data_o;
    logic       pop_ferr_o;
    logic       ready_o;
    logic [4:0] level_o;
    logic       overrun_o;
    logic       clr_ovr_i;
    logic       rts_o;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb [$];
    logic [7:0] last_pop;

    uart_rx_buffer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rst_soft_i  (rst_soft_i),
        .en_i        (en_i),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .push_ferr_i (push_ferr_i),
        .pop_i       (pop_i),
        .pop_data_o  (pop_data_o),
        .pop_ferr_o  (pop_ferr_o),
        .ready_o     (ready_o),
        .level_o     (level_o),
        .overrun_o   (overrun_o),
        .clr_ovr_i   (clr_ovr_i),
        .rts_o       (rts_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One cycle with optional push and/or pop; the scoreboard decides what the
    // FIFO must accept and the head is compared before the read edge.
    task automatic cycle(input logic do_push, input logic [7:0] d, input logic fe,
                         input logic do_pop);
        logic acc;
        if (do_pop) begin
            if (sb.size() > 0) begin
                chk("head", 32'({pop_ferr_o, pop_data_o}), 32'(sb[0]));
                chk("ready_nonempty", 32'(ready_o), 32'd1);
                last_pop = pop_data_o;
            end else begin
                chk("ready_empty", 32'(ready_o), 32'd0);
            end
        end
        acc = do_push && en_i && (sb.size() < 16 || (do_pop && sb.size() > 0));
        push_i = do_push; push_data_i = d; push_ferr_i = fe; pop_i = do_pop;
        tick();
        push_i = 1'b0; pop_i = 1'b0; push_ferr_i = 1'b0;
        if (do_pop && sb.size() > 0) void'(sb.pop_front());
        if (acc) sb.push_back({fe, d});
        chk("level", 32'(level_o), 32'(sb.size()));
    endtask

    task automatic push(input logic [7:0] d, input logic fe = 1'b0);
        cycle(1'b1, d, fe, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        rst_i = 1'b0; rst_soft_i = 1'b0; en_i = 1'b0; push_i = 1'b0;
        push_data_i = 8'h00; push_ferr_i = 1'b0; pop_i = 1'b0; clr_ovr_i = 1'b0;
        last_pop = 8'h00;
        tick(); tick();
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_ovr", 32'(overrun_o), 32'd0);
        chk("rst_rts", 32'(rts_o), 32'd0);
        rst_i = 1'b1; en_i = 1'b1;
        tick();
        chk("rts_after_en", 32'(rts_o), 32'd1);

        // basic order
        push(8'h41); push(8'h42); push(8'h43);
        chk("lvl3", 32'(level_o), 32'd3);
        chk("rdy3", 32'(ready_o), 32'd1);
        chk("rts3", 32'(rts_o), 32'd1);
        pop(); pop(); pop();
        chk("rdy_after_pops", 32'(ready_o), 32'd0);
        pop();  // pop on empty is ignored
        chk("lvl_empty_pop", 32'(level_o), 32'd0);

        // overrun
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("rts_full", 32'(rts_o), 32'd0);
        push(8'hAA);
        chk("ovr_set", 32'(overrun_o), 32'd1);
        chk("lvl_full", 32'(level_o), 32'd16);
        for (int i = 0; i < 16; i++) pop();
        chk("ovr_sticky", 32'(overrun_o), 32'd1);
        clr_ovr_i = 1'b1; tick(); clr_ovr_i = 1'b0;
        chk("ovr_clr", 32'(overrun_o), 32'd0);

        // full with simultaneous push/pop
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        cycle(1'b1, 8'h55, 1'b0, 1'b1);
        chk("full_pp_lvl", 32'(level_o), 32'd16);
        chk("full_pp_ovr", 32'(overrun_o), 32'd0);
        chk("full_pp_head", 32'(last_pop), 32'h80);
        for (int i = 0; i < 16; i++) pop();
        chk("last_is_55", 32'(last_pop), 32'h55);

        // rts hysteresis
        for (int i = 0; i < 11; i++) push(8'(8'h20 + i));
        chk("rts_11", 32'(rts_o), 32'd1);
        push(8'h2B);
        chk("rts_12", 32'(rts_o), 32'd0);
        pop(); pop(); pop();
        chk("rts_9", 32'(rts_o), 32'd0);
        pop();
        chk("rts_8", 32'(rts_o), 32'd1);
        while (sb.size() > 0) pop();

        // framing flag and disabled push
        push(8'h7E, 1'b1);
        chk("ferr_head", 32'(pop_ferr_o), 32'd1);
        chk("ferr_data", 32'(pop_data_o), 32'h7E);
        en_i = 1'b0;
        push(8'h11);
        chk("dis_lvl", 32'(level_o), 32'd1);
        chk("dis_ovr", 32'(overrun_o), 32'd0);
        chk("dis_rts", 32'(rts_o), 32'd0);
        en_i = 1'b1;
        pop();

        // disabled push into a full FIFO never flags overrun
        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
        en_i = 1'b0;
        push(8'hEE);
        chk("dis_full_ovr", 32'(overrun_o), 32'd0);
        en_i = 1'b1;
        while (sb.size() > 0) pop();

        // soft flush with a push in the same cycle
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        rst_soft_i = 1'b1; push_i = 1'b1; push_data_i = 8'hF0;
        tick();
        rst_soft_i = 1'b0; push_i = 1'b0;
        sb.delete();
        chk("flush_lvl", 32'(level_o), 32'd0);
        chk("flush_rdy", 32'(ready_o), 32'd0);
        chk("flush_rts", 32'(rts_o), 32'd0);
        push(8'h99);
        chk("rts_after_flush", 32'(rts_o), 32'd1);
        pop();
        chk("after_flush_data", 32'(last_pop), 32'h99);

        // pointer wrap with one entry in flight
        push(8'd0);
        for (int i = 1; i < 40; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
        pop();
        chk("wrap_last", 32'(last_pop), 32'd39);
        chk("wrap_empty", 32'(ready_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side elastic buffer between the UART receiver shift logic and the CPU register interface. It captures each byte the receiver completes, together with its framing-error flag, into a FIFO. It presents the oldest entry to the RXDATA read path and drives the `rts` flow-control line with hysteresis on FIFO occupancy. It also records overrun when the receiver delivers a byte with the FIFO full.

## Interface
Parameters:
- `ADDR_W`, default 4: log2 of FIFO depth (DEPTH = 2^ADDR_W = 16 entries).
- `RTS_OFF`, default 12: occupancy at or above which `rts_o` deasserts; must satisfy RTS_ON < RTS_OFF <= DEPTH.
- `RTS_ON`, default 8: occupancy at or below which `rts_o` re-asserts.

Ports:
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `rst_soft_i`  in  1  synchronous flush driven by the SOFTRESET register bit, active-high.
- `en_i`  in  1  receive enable (RXEN); when 0, pushes are discarded and `rts_o` is held 0.
- `push_i`  in  1  one-cycle strobe from the receiver: a byte is complete.
- `push_data_i`  in  8  received byte, valid with `push_i`.
- `push_ferr_i`  in  1  framing error (stop bit sampled 0) for that byte.
- `pop_i`  in  1  one-cycle strobe from the register interface: RXDATA read.
- `pop_data_o`  out  8  head-of-FIFO byte (first-word-fall-through).
- `pop_ferr_o`  out  1  framing flag of the head entry.
- `ready_o`  out  1  FIFO non-empty (RXREADY).
- `level_o`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `overrun_o`  out  1  sticky overrun flag.
- `clr_ovr_i`  in  1  clears `overrun_o`.
- `rts_o`  out  1  ready-to-send towards the remote transmitter.

## Operation
- Storage: DEPTH x 9-bit register array {ferr, data}. Write pointer, read pointer and count are ADDR_W, ADDR_W and ADDR_W+1 bits. Both pointers wrap modulo DEPTH naturally. Full = (count == DEPTH). Empty = (count == 0).
- Priority: `rst_i` low, then `rst_soft_i`, then normal operation.
- Accepted push = `push_i & en_i & (!full | pop_accepted)`. It writes the entry at wr_ptr and increments wr_ptr.
- Accepted pop = `pop_i & !empty`. It increments rd_ptr. A pop on empty is ignored: no state change, no error.
- Simultaneous push and pop:
  - When not empty, both are accepted and the count is unchanged. When full, this holds too, because the pop frees the slot in the same cycle.
  - When empty, only the push is accepted and the count becomes 1.
- Overrun: set when `push_i & en_i & full & !pop_i`. The byte is dropped. Overrun stays set until `clr_ovr_i`. If set and clear occur in the same cycle, set wins. A push with `en_i`=0 never sets overrun.
- `pop_data_o` and `pop_ferr_o` = array[rd_ptr], read combinationally from registers. They are undefined when `ready_o`=0.
- RTS hysteresis:
  - An internal flag `rx_ok` clears when the next-cycle count is >= RTS_OFF and sets when it is <= RTS_ON; otherwise it holds.
  - `rts_o` is registered as `en_i & rx_ok`.
- Reset (`rst_i`=0) and flush (`rst_soft_i`=1) have the same effect:
  - pointers, count and `overrun_o` go to 0;
  - `rx_ok` goes to 1 and `rts_o` goes to 0;
  - array contents are not cleared.
  - A push or pop presented in the same cycle is discarded.

## Timing
- Reset values: `ready_o`=0, `level_o`=0, `overrun_o`=0, `rts_o`=0. `pop_data_o` and `pop_ferr_o` are don't-care.
- Push at edge N: `ready_o`, `level_o` and `pop_data_o` reflect it after edge N (1-cycle latency).
- Pop at edge N: the next entry is on `pop_data_o` after edge N. Back-to-back pops every cycle are supported.
- `ready_o` and `level_o` are registered, derived from count.
- `rts_o` changes on the same edge that the count crosses its threshold. It is computed from the next-cycle count and registered.
- `rts_o` rises on the first edge after `en_i` rises, and falls on the first edge after `en_i` falls.
- No combinational path from `push_i` or `pop_i` to any output except `pop_data_o` via rd_ptr (register to output only).

## Test plan
- Reset then `en_i`=1, 3 pushes 0x41,0x42,0x43 → `level_o`=3, `ready_o`=1, `rts_o`=1. 3 pops return 0x41,0x42,0x43 in order, then `ready_o`=0.
- Push 16 bytes 0x00..0x0F, then push 0xAA → 0xAA dropped, `overrun_o`=1, `level_o`=16. Pops return 0x00..0x0F. `clr_ovr_i` clears `overrun_o`.
- Full FIFO, push 0x55 with simultaneous pop → pop returns head, `level_o` stays 16, no overrun, 0x55 is the last entry read.
- RTS hysteresis with defaults:
  - push to 11 → `rts_o`=1; push 12th → `rts_o`=0;
  - pop to 9 → still 0; pop to 8 → `rts_o`=1.
- Push with `push_ferr_i`=1 data 0x7E → `pop_ferr_o`=1 while 0x7E is at head. Push with `en_i`=0 → `level_o` unchanged, `overrun_o` stays 0.
- With 5 entries, assert `rst_soft_i` together with a push → `level_o`=0, `ready_o`=0, push discarded.
- Pointer wrap: 40 push/pop pairs with data = index → all 40 bytes read back in order.
